// File: rtl/bnn_conv1_pkg.sv
// bnn_conv1_pkg: shared constants, field types and FSM state encoding for the conv1 scheduler
package bnn_conv1_pkg;
    localparam int IMG_W   = 28;
    localparam int K       = 5;
    localparam int N_KER   = 12;
    localparam int W_BYTES = 38;
    localparam int OUT_DIM = IMG_W - K + 1;
    localparam int ROW_W   = 5;
    localparam int COL_W   = 5;
    localparam int KIDX_W  = 4;
    localparam int WCNT_W  = $clog2(W_BYTES);
    typedef logic [ROW_W-1:0]  row_t;
    typedef logic [COL_W-1:0]  col_t;
    typedef logic [KIDX_W-1:0] kidx_t;
    typedef logic [WCNT_W-1:0] wcnt_t;
    localparam row_t  ROW_LAST  = row_t'(OUT_DIM - 1);
    localparam col_t  COL_LAST  = col_t'(IMG_W - 1);
    localparam col_t  COL_VMAX  = col_t'(IMG_W - K);
    localparam kidx_t KIDX_LAST = kidx_t'(N_KER - 1);
    localparam wcnt_t WCNT_LAST = wcnt_t'(W_BYTES - 1);
    typedef enum logic [2:0] {IDLE, LOAD_W, WAIT_WIN, RUN_K, WAIT_MAC, ADV, DONE} state_t;
endpackage

// File: rtl/conv1_win_pos.sv
// conv1_win_pos: raster row/col tracker for the conv1 window sweep with last-window and valid flags
module conv1_win_pos
    import bnn_conv1_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             last,
    output logic             pos_valid
);
    assign last      = (row == ROW_LAST) && (col == COL_LAST);
    assign pos_valid = col <= COL_VMAX;
    // Step through the raster; the final window leaves the position where it is
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (adv && !last) begin
            row <= (col == COL_LAST) ? row + row_t'(1) : row;
            col <= (col == COL_LAST) ? '0 : col + col_t'(1);
        end
    end
endmodule

// File: rtl/conv1_sched.sv
// conv1_sched: conv1 layer controller - weight load, window sweep, per-kernel MAC sequencing
// Defining CONV1_SCHED_PERF_EN adds the saturating perf_stall stall-cycle counter output.
module conv1_sched
    import bnn_conv1_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              cfg_skip_w,
    input  logic              src_valid,
    output logic              src_ready,
    output logic              ld_mode,
    output logic              ld_valid,
    input  logic              ld_ready,
    input  logic              ld_win,
    output logic              ld_over,
    output logic              mac_start,
    output logic [KIDX_W-1:0] mac_kidx,
    input  logic              mac_done,
    output logic [ROW_W-1:0]  pos_row,
    output logic [COL_W-1:0]  pos_col,
    output logic              pos_valid,
    output logic              busy,
    output logic              done,
`ifdef CONV1_SCHED_PERF_EN
    output logic [15:0]       perf_stall,
`endif
    output logic              err_win
);
    state_t state;
    kidx_t  kidx;
    wcnt_t  wcnt;
    logic   gate_open, accept, go, last, col_ok;

    assign gate_open = state inside {LOAD_W, WAIT_WIN, RUN_K, WAIT_MAC, ADV};
    assign src_ready = ld_ready & gate_open;
    assign ld_valid  = src_valid & gate_open;
    assign accept    = src_valid & src_ready;
    assign go        = start & (state == IDLE);
    assign pos_valid = busy & col_ok;
    assign mac_kidx  = kidx;

    conv1_win_pos u_pos (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (go),
        .adv       (state == ADV),
        .row       (pos_row),
        .col       (pos_col),
        .last      (last),
        .pos_valid (col_ok)
    );

    // Layer FSM with registered one-cycle strobes; stray windows are flagged and dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ld_mode   <= 1'b0;
            ld_over   <= 1'b0;
            mac_start <= 1'b0;
            done      <= 1'b0;
            busy      <= 1'b0;
            err_win   <= 1'b0;
            kidx      <= '0;
            wcnt      <= '0;
        end else begin
            ld_over   <= 1'b0;
            mac_start <= 1'b0;
            done      <= 1'b0;
            if (ld_win && state != WAIT_WIN)
                err_win <= 1'b1;
            case (state)
                IDLE: if (start) begin
                    busy    <= 1'b1;
                    err_win <= 1'b0;
                    kidx    <= '0;
                    wcnt    <= '0;
                    ld_mode <= !cfg_skip_w;
                    state   <= cfg_skip_w ? WAIT_WIN : LOAD_W;
                end
                LOAD_W: if (accept) begin
                    wcnt <= wcnt + wcnt_t'(1);
                    if (wcnt == WCNT_LAST) begin
                        ld_mode <= 1'b0;
                        state   <= WAIT_WIN;
                    end
                end
                WAIT_WIN: if (ld_win) begin
                    kidx  <= '0;
                    state <= col_ok ? RUN_K : ADV;
                end
                RUN_K: begin
                    mac_start <= 1'b1;
                    state     <= WAIT_MAC;
                end
                WAIT_MAC: if (mac_done) begin
                    if (kidx == KIDX_LAST)
                        state <= ADV;
                    else begin
                        kidx  <= kidx + kidx_t'(1);
                        state <= RUN_K;
                    end
                end
                ADV: begin
                    ld_over <= 1'b1;
                    state   <= last ? DONE : WAIT_WIN;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV1_SCHED_PERF_EN
    // Stall counter: MAC wait cycles plus window-wait cycles with no upstream data
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            perf_stall <= '0;
        else if (go)
            perf_stall <= '0;
        else if (((state == WAIT_MAC) || (state == WAIT_WIN && !src_valid)) && perf_stall != 16'hFFFF)
            perf_stall <= perf_stall + 16'd1;
    end
`endif
endmodule

// File: tb/tb_conv1_sched.sv
// tb_conv1_sched: randomized self-checking bench for conv1_sched against a raster/window reference model
module tb_conv1_sched;
    localparam int M_W   = 28;
    localparam int M_K   = 5;
    localparam int M_NK  = 12;
    localparam int M_WB  = 38;
    localparam int M_WIN = M_W * (M_W - M_K + 1);

    logic clk = 0, rst_n = 0, start = 0, cfg_skip_w = 0, src_valid = 0, ld_ready = 0, ld_win = 0;
    logic mac_done_auto = 0, mac_done_force = 0;
    logic src_ready, ld_mode, ld_valid, ld_over, mac_start, pos_valid, busy, done, err_win;
    logic [3:0] mac_kidx;
    logic [4:0] pos_row, pos_col;
`ifdef CONV1_SCHED_PERF_EN
    logic [15:0] perf_stall;
`endif
    int n_chk = 0, n_fail = 0;
    int n_start = 0, n_over = 0, n_done = 0, cd = 0, lat_min = 2, lat_max = 2;
    int klog[$];
    bit mac_en = 0;

    conv1_sched dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .cfg_skip_w (cfg_skip_w),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .ld_mode    (ld_mode),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_win     (ld_win),
        .ld_over    (ld_over),
        .mac_start  (mac_start),
        .mac_kidx   (mac_kidx),
        .mac_done   (mac_done_auto | mac_done_force),
        .pos_row    (pos_row),
        .pos_col    (pos_col),
        .pos_valid  (pos_valid),
        .busy       (busy),
        .done       (done),
`ifdef CONV1_SCHED_PERF_EN
        .perf_stall (perf_stall),
`endif
        .err_win    (err_win)
    );

    always #5 clk = ~clk;

    // MAC model: answers each mac_start after a random latency
    always @(negedge clk) begin
        mac_done_auto = 1'b0;
        if (!rst_n)
            cd = 0;
        else if (mac_en) begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) mac_done_auto = 1'b1;
            end
            if (mac_start) cd = int'($urandom_range(lat_max, lat_min));
        end
    end

    // Event monitor: counts strobes and logs the kernel index of each MAC start
    always @(negedge clk) begin
        if (mac_start) begin
            n_start++;
            klog.push_back(int'(mac_kidx));
        end
        if (ld_over) n_over++;
        if (done) n_done++;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic drive_window(input int gap_max, output int starts, output int overs, output int kbase, output bit tout);
        int s0, o0;
        s0 = n_start;
        o0 = n_over;
        kbase = n_start;
        tout = 1'b1;
        repeat ($urandom_range(gap_max, 0)) tick;
        ld_win = 1'b1;
        tick;
        ld_win = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (n_over != o0) begin
                tout = 1'b0;
                break;
            end
            tick;
        end
        starts = n_start - s0;
        overs = n_over - o0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        src_valid = 1'b1;
        ld_ready = 1'b1;
        repeat (3) tick;
        n_chk++;
        if ({busy, done, ld_mode, ld_over, mac_start, pos_valid, err_win, src_ready, ld_valid} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000000", {busy, done, ld_mode, ld_over, mac_start, pos_valid, err_win, src_ready, ld_valid});
        end
        n_chk++;
        if ({mac_kidx, pos_row, pos_col} !== 14'b0) begin
            n_fail++;
            $display("FAIL reset_fields: kidx=%0d row=%0d col=%0d want 0", mac_kidx, pos_row, pos_col);
        end
`ifdef CONV1_SCHED_PERF_EN
        n_chk++;
        if (perf_stall !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_perf: got %0d want 0", perf_stall);
        end
`endif
        rst_n = 1'b1;
        tick;
        n_chk++;
        if (src_ready !== 1'b0 || busy !== 1'b0 || ld_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_gate: src_ready=%b busy=%b ld_valid=%b want 0 0 0", src_ready, busy, ld_valid);
        end
        src_valid = 1'b0;
    endtask

    task automatic test_weight_load;
        int acc = 0, cyc = 0;
        bit ok_mode = 1'b1, ok_gate = 1'b1;
        cfg_skip_w = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        cfg_skip_w = 1'b1;
        n_chk++;
        if (busy !== 1'b1 || ld_mode !== 1'b1) begin
            n_fail++;
            $display("FAIL wload_enter: busy=%b ld_mode=%b want 1 1", busy, ld_mode);
        end
        while (acc < M_WB && cyc < 2000) begin
            src_valid = 1'($urandom_range(1, 0));
            ld_ready = 1'($urandom_range(1, 0));
            #1;
            if (ld_mode !== 1'b1) ok_mode = 1'b0;
            if (src_ready !== ld_ready || ld_valid !== src_valid) ok_gate = 1'b0;
            if (src_valid && src_ready) acc++;
            tick;
            cyc++;
        end
        n_chk++;
        if (acc != M_WB) begin
            n_fail++;
            $display("FAIL wload_count: accepted %0d bytes want %0d", acc, M_WB);
        end
        n_chk++;
        if (!ok_mode) begin
            n_fail++;
            $display("FAIL wload_mode: ld_mode dropped before byte %0d", M_WB);
        end
        n_chk++;
        if (!ok_gate) begin
            n_fail++;
            $display("FAIL wload_gate: src_ready/ld_valid did not follow ld_ready/src_valid");
        end
        n_chk++;
        if (ld_mode !== 1'b0) begin
            n_fail++;
            $display("FAIL wload_exit: ld_mode=%b want 0 after last byte", ld_mode);
        end
        src_valid = 1'b0;
        ld_ready = 1'b1;
        #1;
        n_chk++;
        if (src_ready !== 1'b1 || busy !== 1'b1 || mac_start !== 1'b0 || ld_over !== 1'b0) begin
            n_fail++;
            $display("FAIL wload_waitwin: src_ready=%b busy=%b mac_start=%b ld_over=%b want 1 1 0 0", src_ready, busy, mac_start, ld_over);
        end
    endtask

    task automatic test_valid_window;
        int s, o, kb;
        bit to;
        mac_en = 1'b1;
        lat_min = 2;
        lat_max = 2;
        n_chk++;
        if (pos_row !== 5'd0 || pos_col !== 5'd0 || pos_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL vwin_pos0: row=%0d col=%0d valid=%b want 0 0 1", pos_row, pos_col, pos_valid);
        end
        drive_window(0, s, o, kb, to);
        n_chk++;
        if (to || s != M_NK) begin
            n_fail++;
            $display("FAIL vwin_starts: got %0d mac_start (timeout=%0b) want %0d", s, to, M_NK);
        end
        for (int i = 0; i < M_NK; i++) begin
            n_chk++;
            if (kb + i >= klog.size() || klog[kb+i] != i) begin
                n_fail++;
                $display("FAIL vwin_kidx%0d: got %0d want %0d", i, (kb + i < klog.size()) ? klog[kb+i] : -1, i);
            end
        end
        n_chk++;
        if (o != 1 || pos_row !== 5'd0 || pos_col !== 5'd1) begin
            n_fail++;
            $display("FAIL vwin_adv: over=%0d row=%0d col=%0d want 1 0 1", o, pos_row, pos_col);
        end
    endtask

    task automatic test_invalid_window;
        int s, o, kb, s0;
        bit to;
        for (int n = 1; n < M_W - M_K + 1; n++) begin
            drive_window(1, s, o, kb, to);
            n_chk++;
            if (to || s != M_NK || o != 1) begin
                n_fail++;
                $display("FAIL row0_win%0d: starts=%0d over=%0d timeout=%0b want %0d 1 0", n, s, o, to, M_NK);
            end
        end
        n_chk++;
        if (pos_row !== 5'd0 || pos_col !== 5'(M_W - M_K + 1) || pos_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL iwin_pos: row=%0d col=%0d valid=%b want 0 %0d 0", pos_row, pos_col, pos_valid, M_W - M_K + 1);
        end
        s0 = n_start;
        ld_win = 1'b1;
        tick;
        ld_win = 1'b0;
        n_chk++;
        if (ld_over !== 1'b0 || mac_start !== 1'b0) begin
            n_fail++;
            $display("FAIL iwin_c1: ld_over=%b mac_start=%b want 0 0", ld_over, mac_start);
        end
        tick;
        n_chk++;
        if (ld_over !== 1'b1 || pos_col !== 5'(M_W - M_K + 2) || n_start != s0) begin
            n_fail++;
            $display("FAIL iwin_c2: ld_over=%b col=%0d starts=%0d want 1 %0d 0", ld_over, pos_col, n_start - s0, M_W - M_K + 2);
        end
    endtask

    task automatic test_error_ignore;
        int s, o, kb, s0, o0;
        bit to, injected = 1'b0;
        for (int n = M_W - M_K + 2; n < M_W; n++) begin
            drive_window(0, s, o, kb, to);
            n_chk++;
            if (to || s != 0 || o != 1) begin
                n_fail++;
                $display("FAIL row0_inv%0d: starts=%0d over=%0d timeout=%0b want 0 1 0", n, s, o, to);
            end
        end
        s0 = n_start;
        o0 = n_over;
        mac_done_force = 1'b1;
        tick;
        mac_done_force = 1'b0;
        repeat (3) tick;
        n_chk++;
        if (n_start != s0 || n_over != o0 || pos_row !== 5'd1 || pos_col !== 5'd0 || err_win !== 1'b0) begin
            n_fail++;
            $display("FAIL macdone_ignored: starts=%0d overs=%0d row=%0d col=%0d err=%b want 0 0 1 0 0", n_start - s0, n_over - o0, pos_row, pos_col, err_win);
        end
        cfg_skip_w = 1'b0;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        n_chk++;
        if (ld_mode !== 1'b0 || busy !== 1'b1 || pos_row !== 5'd1 || pos_col !== 5'd0) begin
            n_fail++;
            $display("FAIL start_busy: ld_mode=%b busy=%b row=%0d col=%0d want 0 1 1 0", ld_mode, busy, pos_row, pos_col);
        end
        kb = n_start;
        ld_win = 1'b1;
        tick;
        ld_win = 1'b0;
        for (int i = 0; i < 400 && n_over == o0; i++) begin
            if (!injected && mac_start && mac_kidx == 4'd3) begin
                injected = 1'b1;
                ld_win = 1'b1;
                tick;
                ld_win = 1'b0;
            end else
                tick;
        end
        n_chk++;
        if (!injected || err_win !== 1'b1) begin
            n_fail++;
            $display("FAIL err_win: injected=%0b err_win=%b want 1 1", injected, err_win);
        end
        n_chk++;
        if (n_start - kb != M_NK || n_over - o0 != 1 || pos_col !== 5'd1) begin
            n_fail++;
            $display("FAIL err_window: starts=%0d overs=%0d col=%0d want %0d 1 1", n_start - kb, n_over - o0, pos_col, M_NK);
        end
        for (int i = 0; i < M_NK; i++) begin
            n_chk++;
            if (kb + i >= klog.size() || klog[kb+i] != i) begin
                n_fail++;
                $display("FAIL err_kidx%0d: got %0d want %0d", i, (kb + i < klog.size()) ? klog[kb+i] : -1, i);
            end
        end
    endtask

    task automatic test_reset_mid_run;
        int s, o, kb, s0;
        bit to, hit = 1'b0;
        s0 = n_start;
        ld_win = 1'b1;
        tick;
        ld_win = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (n_start - s0 == 5 && mac_kidx == 4'd5 && !mac_start) begin
                hit = 1'b1;
                break;
            end
            tick;
        end
        n_chk++;
        if (!hit) begin
            n_fail++;
            $display("FAIL rst_mid_reach: kernel 5 issue point not reached, starts=%0d want 5", n_start - s0);
        end
        rst_n = 1'b0;
        #1;
        n_chk++;
        if ({busy, done, ld_mode, ld_over, mac_start, pos_valid, err_win, src_ready, mac_kidx, pos_row, pos_col} !== 23'b0) begin
            n_fail++;
            $display("FAIL rst_mid_outs: busy=%b over=%b err=%b ready=%b kidx=%0d row=%0d col=%0d want all 0", busy, ld_over, err_win, src_ready, mac_kidx, pos_row, pos_col);
        end
        tick;
        rst_n = 1'b1;
        tick;
        cfg_skip_w = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        n_chk++;
        if (busy !== 1'b1 || ld_mode !== 1'b0 || pos_row !== 5'd0 || pos_col !== 5'd0 || pos_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL rst_restart: busy=%b ld_mode=%b row=%0d col=%0d valid=%b want 1 0 0 0 1", busy, ld_mode, pos_row, pos_col, pos_valid);
        end
        drive_window(0, s, o, kb, to);
        n_chk++;
        if (to || s != M_NK || o != 1 || pos_col !== 5'd1 || kb >= klog.size() || klog[kb] != 0) begin
            n_fail++;
            $display("FAIL rst_rerun: starts=%0d over=%0d col=%0d first_kidx=%0d want %0d 1 1 0", s, o, pos_col, (kb < klog.size()) ? klog[kb] : -1, M_NK);
        end
    endtask

    task automatic test_full_layer;
        int s, o, kb, s0, o0, d0, er, ec;
        bit to;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        tick;
        lat_min = 1;
        lat_max = 3;
        s0 = n_start;
        o0 = n_over;
        d0 = n_done;
        cfg_skip_w = 1'b1;
        start = 1'b1;
        tick;
        start = 1'b0;
        for (int n = 0; n < M_WIN; n++) begin
            er = n / M_W;
            ec = n % M_W;
            n_chk++;
            if (pos_row !== 5'(er) || pos_col !== 5'(ec) || pos_valid !== (ec <= M_W - M_K) || busy !== 1'b1 || n_done != d0) begin
                n_fail++;
                $display("FAIL layer_pos%0d: row=%0d col=%0d valid=%b busy=%b want %0d %0d %0b 1", n, pos_row, pos_col, pos_valid, busy, er, ec, ec <= M_W - M_K);
            end
            drive_window(1, s, o, kb, to);
            n_chk++;
            if (to || o != 1 || s != ((ec <= M_W - M_K) ? M_NK : 0)) begin
                n_fail++;
                $display("FAIL layer_win%0d: starts=%0d over=%0d timeout=%0b want %0d 1 0", n, s, o, to, (ec <= M_W - M_K) ? M_NK : 0);
            end
            if (to) break;
        end
        tick;
        n_chk++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL layer_done: done=%b busy=%b want 1 0", done, busy);
        end
        tick;
        n_chk++;
        if (n_start - s0 != M_NK * (M_W - M_K + 1) * (M_W - M_K + 1) || n_over - o0 != M_WIN) begin
            n_fail++;
            $display("FAIL layer_totals: starts=%0d overs=%0d want %0d %0d", n_start - s0, n_over - o0, M_NK * (M_W - M_K + 1) * (M_W - M_K + 1), M_WIN);
        end
        n_chk++;
        if (n_done - d0 != 1 || done !== 1'b0 || busy !== 1'b0 || err_win !== 1'b0 || pos_row !== 5'(M_W - M_K) || pos_col !== 5'(M_W - 1)) begin
            n_fail++;
            $display("FAIL layer_end: dones=%0d done=%b busy=%b err=%b row=%0d col=%0d want 1 0 0 0 %0d %0d", n_done - d0, done, busy, err_win, pos_row, pos_col, M_W - M_K, M_W - 1);
        end
    endtask

    initial begin
        test_reset();
        test_weight_load();
        test_valid_window();
        test_invalid_window();
        test_error_ignore();
        test_reset_mid_run();
        test_full_layer();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
